// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and encodings for the pipeline hazard scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Destination field is sized for the largest supported register file; narrower indices are zero-extended.
    localparam int RD_W   = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module : hazard_match
// Brief  : Youngest-match priority encoder over the scoreboard slots.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_match
    import hazard_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int RW    = 3,
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input  slot_t [DEPTH-1:0] i_slots,
    input  logic              i_en,
    input  logic [RW-1:0]     i_src,
    output logic              o_hit,
    output logic [SW-1:0]     o_idx,
    output logic              o_is_load
);

    // Scanning oldest to youngest lets the lowest matching index overwrite the rest.
    always_comb begin
        o_hit     = 1'b0;
        o_idx     = '0;
        o_is_load = 1'b0;
        if (i_en) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (i_slots[i].valid && (i_slots[i].rd == RD_W'(i_src))) begin
                    o_hit     = 1'b1;
                    o_idx     = SW'(i);
                    o_is_load = i_slots[i].is_load;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : ID-stage stall/forward decision over a shift scoreboard of in-flight writes.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NREG      = 8,
    parameter  int DEPTH     = 3,
    parameter  int LOAD_SLOT = 2,
    parameter  int FWD       = 1,
    parameter  int RF_BYPASS = 1,
    parameter  int KILL      = 0,
    localparam int RW        = $clog2(NREG),
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [1:0]    id_rs_en,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rd_en,
    input  logic [RW-1:0] id_rd,
    input  logic          id_is_load,
    input  logic          flush,
    input  logic          mem_stall,
    output logic          stall,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic          busy,
    output logic [15:0]   stall_count
);

    slot_t [DEPTH-1:0] slot_q, slot_d, w_killed;
    logic  [15:0]      count_q, count_d;

    logic          w_hit_a, w_hit_b, w_ld_a, w_ld_b;
    logic [SW-1:0] w_idx_a, w_idx_b;
    logic [SW:0]   w_res_a, w_res_b;
    logic          w_issue;

    hazard_match #(.DEPTH(DEPTH), .RW(RW)) u_match_a (
        .i_slots   (slot_q),
        .i_en      (id_rs_en[0]),
        .i_src     (id_rs1),
        .o_hit     (w_hit_a),
        .o_idx     (w_idx_a),
        .o_is_load (w_ld_a)
    );

    hazard_match #(.DEPTH(DEPTH), .RW(RW)) u_match_b (
        .i_slots   (slot_q),
        .i_en      (id_rs_en[1]),
        .i_src     (id_rs2),
        .o_hit     (w_hit_b),
        .o_idx     (w_idx_b),
        .o_is_load (w_ld_b)
    );

    // Returns {ready, fwd}; the consumer meets its producer one slot further along in EX.
    function automatic logic [SW:0] resolve(input logic hit, input logic [SW-1:0] idx,
                                            input logic is_load);
        logic [SW-1:0] nxt;
        nxt = idx + SW'(1);
        if (!hit)
            return {1'b1, SW'(FWD_RF)};
        if ((RF_BYPASS != 0) && (idx == SW'(DEPTH - 1)))
            return {1'b1, SW'(FWD_RF)};
        if (FWD == 0)
            return {1'b0, SW'(FWD_RF)};
        if (is_load)
            return {(nxt >= SW'(LOAD_SLOT)), nxt};
        return {(nxt <= SW'(DEPTH - 1)), nxt};
    endfunction

    always_comb begin
        w_res_a = resolve(w_hit_a, w_idx_a, w_ld_a);
        w_res_b = resolve(w_hit_b, w_idx_b, w_ld_b);
        stall   = id_valid & ~flush & ~(w_res_a[SW] & w_res_b[SW]);
        fwd_a   = w_res_a[SW-1:0];
        fwd_b   = w_res_b[SW-1:0];
        w_issue = id_valid & id_rd_en & ~stall & ~flush;
    end

    always_comb begin
        w_killed = slot_q;
        if (flush) begin
            for (int i = 0; i < KILL; i++)
                w_killed[i].valid = 1'b0;
        end
        slot_d = w_killed;
        if (!mem_stall) begin
            for (int i = 1; i < DEPTH; i++)
                slot_d[i] = w_killed[i-1];
            slot_d[0] = w_issue ? '{valid: 1'b1, rd: RD_W'(id_rd), is_load: id_is_load} : '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (stall && !mem_stall && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q  <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            busy = busy | slot_q[i].valid;
        stall_count = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Directed bench for hazard_scoreboard (default and no-forward builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [1:0] id_rs_en;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       id_rd_en, id_is_load, flush, mem_stall;

    logic        s0_stall, s0_busy, s1_stall, s1_busy;
    logic [1:0]  s0_fwd_a, s0_fwd_b, s1_fwd_a, s1_fwd_b;
    logic [15:0] s0_cnt, s1_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd_en(id_rd_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
        .stall(s0_stall), .fwd_a(s0_fwd_a), .fwd_b(s0_fwd_b),
        .busy(s0_busy), .stall_count(s0_cnt)
    );

    hazard_scoreboard #(.FWD(0)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd_en(id_rd_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
        .stall(s1_stall), .fwd_a(s1_fwd_a), .fwd_b(s1_fwd_b),
        .busy(s1_busy), .stall_count(s1_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage vector and let combinational outputs settle.
    task automatic drv(input logic v, input logic [1:0] en, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic rde, input logic [2:0] rd,
                       input logic ld, input logic fl, input logic ms);
        id_valid = v; id_rs_en = en; id_rs1 = rs1; id_rs2 = rs2;
        id_rd_en = rde; id_rd = rd; id_is_load = ld; flush = fl; mem_stall = ms;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b0;
        drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("rst_stall", s0_stall, 0);
        chk("rst_fwd_a", s0_fwd_a, 0);
        chk("rst_fwd_b", s0_fwd_b, 0);
        chk("rst_busy",  s0_busy,  0);
        chk("rst_cnt",   s0_cnt,   0);

        // ALU producer at distance 1, 2, 3
        drv(1, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        chk("t1_issue_stall", s0_stall, 0);
        tick();
        drv(1, 2'b01, 1, 0, 1, 2, 0, 0, 0);
        chk("t1_d1_stall", s0_stall, 0);
        chk("t1_d1_fwd_a", s0_fwd_a, 1);
        tick();
        drv(1, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_d2_stall", s0_stall, 0);
        chk("t1_d2_fwd_a", s0_fwd_a, 2);
        chk("t1_busy",     s0_busy,  1);
        tick();
        drv(1, 2'b11, 1, 2, 0, 0, 0, 0, 0);
        chk("t1_d3_stall", s0_stall, 0);
        chk("t1_d3_fwd_a", s0_fwd_a, 0);
        chk("t1_d3_fwd_b", s0_fwd_b, 2);
        idle(3);
        chk("t1_drained", s0_busy, 0);

        // load-use
        drv(1, 2'b00, 0, 0, 1, 3, 1, 0, 0);
        tick();
        drv(1, 2'b01, 3, 0, 1, 4, 0, 0, 0);
        chk("t2_lu_stall", s0_stall, 1);
        chk("t2_cnt0",     s0_cnt,   0);
        tick();
        chk("t2_cnt1",     s0_cnt,   1);
        chk("t2_ok_stall", s0_stall, 0);
        chk("t2_ok_fwd_a", s0_fwd_a, 2);
        tick();
        idle(3);

        // youngest match and disabled sources
        drv(1, 2'b00, 0, 0, 1, 4, 0, 0, 0);
        tick();
        drv(1, 2'b00, 0, 0, 1, 4, 0, 0, 0);
        tick();
        drv(1, 2'b10, 0, 4, 0, 0, 0, 0, 0);
        chk("t3_young_stall", s0_stall, 0);
        chk("t3_young_fwd_b", s0_fwd_b, 1);
        drv(1, 2'b00, 4, 4, 0, 0, 0, 0, 0);
        chk("t3_dis_stall", s0_stall, 0);
        chk("t3_dis_fwd_a", s0_fwd_a, 0);
        chk("t3_dis_fwd_b", s0_fwd_b, 0);
        idle(3);

        // load-use frozen by memory stall
        drv(1, 2'b00, 0, 0, 1, 5, 1, 0, 0);
        tick();
        drv(1, 2'b01, 5, 0, 0, 0, 0, 0, 1);
        chk("t4_stall_pre", s0_stall, 1);
        repeat (3) tick();
        chk("t4_frozen_stall", s0_stall, 1);
        chk("t4_frozen_cnt",   s0_cnt,   1);
        chk("t4_frozen_busy",  s0_busy,  1);
        drv(1, 2'b01, 5, 0, 0, 0, 0, 0, 0);
        chk("t4_rel_stall", s0_stall, 1);
        tick();
        chk("t4_cnt2",     s0_cnt,   2);
        chk("t4_ok_stall", s0_stall, 0);
        chk("t4_ok_fwd_a", s0_fwd_a, 2);
        tick();

        // mid-run reset with three live slots
        drv(1, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        tick();
        drv(1, 2'b00, 0, 0, 1, 2, 0, 0, 0);
        tick();
        drv(1, 2'b00, 0, 0, 1, 3, 0, 0, 0);
        tick();
        drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_busy_pre", s0_busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drv(1, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_busy",  s0_busy,  0);
        chk("t6_cnt",   s0_cnt,   0);
        chk("t6_stall", s0_stall, 0);
        chk("t6_fwd_a", s0_fwd_a, 0);
        chk("t6_u1_cnt", s1_cnt,  0);

        // no-forward build: wait for RF write-before-read, then flush over a hazard
        drv(1, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        tick();
        drv(1, 2'b01, 1, 0, 1, 2, 0, 0, 0);
        chk("t5_s1_stall", s1_stall, 1);
        tick();
        chk("t5_s2_stall", s1_stall, 1);
        tick();
        chk("t5_ok_stall", s1_stall, 0);
        chk("t5_ok_fwd_a", s1_fwd_a, 0);
        chk("t5_cnt2",     s1_cnt,   2);
        tick();
        drv(1, 2'b01, 2, 0, 1, 3, 0, 1, 0);
        chk("t5_flush_stall", s1_stall, 0);
        tick();
        drv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0);
        chk("t5_bubble_stall", s1_stall, 0);
        chk("t5_bubble_fwd_a", s1_fwd_a, 0);
        chk("t5_flush_cnt",    s1_cnt,   2);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
